// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter that shares one APB master command port among NUM_REQ requesters.
// One transaction at a time: IDLE (arbitrate) -> XFER (drive master, wait/timeout) -> RESP (done pulse).
module apb_req_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                             PCLK,
    input  logic                             PRESET,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ-1:0]               req_rw,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               gnt,
    output logic [NUM_REQ-1:0]               done,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_err,
    output logic                             busy,
    output logic                             transfer,
    output logic                             READ_WRITE,
    output logic [ADDR_WIDTH-1:0]            apb_write_paddr,
    output logic [ADDR_WIDTH-1:0]            apb_read_paddr,
    output logic [DATA_WIDTH-1:0]            apb_write_data,
    input  logic                             apb_done,
    input  logic                             PSLVERR,
    input  logic [DATA_WIDTH-1:0]            apb_read_data_out
);

    localparam int unsigned NR    = NUM_REQ;
    localparam int          IDX_W = $clog2(NUM_REQ);
    localparam int          CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        last_gnt_q, last_gnt_d;
    logic [IDX_W-1:0]        gidx_q, gidx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_REQ-1:0]      gnt_q, gnt_d;
    logic [NUM_REQ-1:0]      done_q, done_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;
    logic                    busy_q, busy_d;
    logic                    transfer_q, transfer_d;
    logic                    rw_q, rw_d;
    logic [ADDR_WIDTH-1:0]   wpaddr_q, wpaddr_d;
    logic [ADDR_WIDTH-1:0]   rpaddr_q, rpaddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [IDX_W-1:0]        pick_idx;
    logic [ADDR_WIDTH-1:0]   pick_addr;
    logic [DATA_WIDTH-1:0]   pick_wdata;

    // First set request searching upward from the slot after the last grant, wrapping.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                 input logic [IDX_W-1:0]   last);
        int unsigned cand;
        logic        found;
        rr_pick = last;
        found   = 1'b0;
        for (int unsigned i = 1; i <= NR; i++) begin
            cand = (32'(last) + i) % NR;
            if (!found && r[IDX_W'(cand)]) begin
                rr_pick = IDX_W'(cand);
                found   = 1'b1;
            end
        end
    endfunction

    always_comb begin
        pick_idx   = rr_pick(req, last_gnt_q);
        pick_addr  = req_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
        pick_wdata = req_wdata[pick_idx*DATA_WIDTH +: DATA_WIDTH];
    end

    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        gidx_d      = gidx_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        done_d      = '0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        busy_d      = busy_q;
        transfer_d  = transfer_q;
        rw_d        = rw_q;
        wpaddr_d    = wpaddr_q;
        rpaddr_d    = rpaddr_q;
        wdata_d     = wdata_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (|req) begin
                    state_d          = XFER;
                    gidx_d           = pick_idx;
                    gnt_d            = '0;
                    gnt_d[pick_idx]  = 1'b1;
                    busy_d           = 1'b1;
                    transfer_d       = 1'b1;
                    rw_d             = req_rw[pick_idx];
                    rpaddr_d         = req_rw[pick_idx] ? pick_addr : '0;
                    wpaddr_d         = req_rw[pick_idx] ? '0 : pick_addr;
                    wdata_d          = req_rw[pick_idx] ? '0 : pick_wdata;
                end
            end
            XFER: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A real completion beats the timeout when both land in the same cycle.
                if (apb_done || (cnt_q == CNT_W'(TIMEOUT - 1))) begin
                    state_d     = RESP;
                    done_d      = gnt_q;
                    rsp_err_d   = apb_done ? PSLVERR : 1'b1;
                    rsp_rdata_d = (apb_done && rw_q) ? apb_read_data_out : '0;
                    transfer_d  = 1'b0;
                    rw_d        = 1'b0;
                    wpaddr_d    = '0;
                    rpaddr_d    = '0;
                    wdata_d     = '0;
                end
            end
            RESP: begin
                state_d    = IDLE;
                last_gnt_d = gidx_q;
                cnt_d      = '0;
                gnt_d      = '0;
                busy_d     = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q     <= IDLE;
            last_gnt_q  <= IDX_W'(NUM_REQ - 1);
            gidx_q      <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            transfer_q  <= 1'b0;
            rw_q        <= 1'b0;
            wpaddr_q    <= '0;
            rpaddr_q    <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            gidx_q      <= gidx_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
            transfer_q  <= transfer_d;
            rw_q        <= rw_d;
            wpaddr_q    <= wpaddr_d;
            rpaddr_q    <= rpaddr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign gnt             = gnt_q;
    assign done            = done_q;
    assign rsp_rdata       = rsp_rdata_q;
    assign rsp_err         = rsp_err_q;
    assign busy            = busy_q;
    assign transfer        = transfer_q;
    assign READ_WRITE      = rw_q;
    assign apb_write_paddr = wpaddr_q;
    assign apb_read_paddr  = rpaddr_q;
    assign apb_write_data  = wdata_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Randomized transaction-level bench for apb_req_arbiter; the bench plays both requesters and APB master.
module tb_apb_req_arbiter;

    localparam int NR = 4;
    localparam int AW = 9;
    localparam int DW = 8;
    localparam int TO = 16;

    logic              PCLK = 1'b0;
    logic              PRESET = 1'b1;
    logic [NR-1:0]     req = '0;
    logic [NR-1:0]     req_rw = '0;
    logic [NR*AW-1:0]  req_addr = '0;
    logic [NR*DW-1:0]  req_wdata = '0;
    logic [NR-1:0]     gnt, done;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err, busy, transfer, READ_WRITE;
    logic [AW-1:0]     apb_write_paddr, apb_read_paddr;
    logic [DW-1:0]     apb_write_data;
    logic              apb_done = 1'b0;
    logic              PSLVERR = 1'b0;
    logic [DW-1:0]     apb_read_data_out = '0;

    int n_cmp = 0;
    int n_bad = 0;

    // Requester-side view kept by the bench, plus the round-robin pointer of the reference model.
    logic              m_rw[NR];
    logic [AW-1:0]     m_addr[NR];
    logic [DW-1:0]     m_wdata[NR];
    int                m_last;

    apb_req_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .req(req), .req_rw(req_rw), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt(gnt), .done(done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .busy(busy), .transfer(transfer), .READ_WRITE(READ_WRITE),
        .apb_write_paddr(apb_write_paddr), .apb_read_paddr(apb_read_paddr),
        .apb_write_data(apb_write_data), .apb_done(apb_done), .PSLVERR(PSLVERR),
        .apb_read_data_out(apb_read_data_out)
    );

    always #5 PCLK = ~PCLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    function automatic int model_pick(input logic [NR-1:0] r);
        for (int i = 1; i <= NR; i++) begin
            int c = (m_last + i) % NR;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic drive_reqs(input logic [NR-1:0] rv);
        req = rv;
        for (int i = 0; i < NR; i++) begin
            req_rw[i]              = m_rw[i];
            req_addr[i*AW +: AW]   = m_addr[i];
            req_wdata[i*DW +: DW]  = m_wdata[i];
        end
    endtask

    task automatic scramble_reqs(input int keep);
        for (int i = 0; i < NR; i++) begin
            if (i != keep) begin
                m_rw[i]    = 1'($urandom);
                m_addr[i]  = AW'($urandom);
                m_wdata[i] = DW'($urandom);
            end
        end
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_gnt"},      32'(gnt), 32'(0));
        check_eq({tag, "_done"},     32'(done), 32'(0));
        check_eq({tag, "_rdata"},    32'(rsp_rdata), 32'(0));
        check_eq({tag, "_err"},      32'(rsp_err), 32'(0));
        check_eq({tag, "_busy"},     32'(busy), 32'(0));
        check_eq({tag, "_transfer"}, 32'(transfer), 32'(0));
        check_eq({tag, "_cmd"},      32'({READ_WRITE, apb_write_paddr, apb_read_paddr, apb_write_data}), 32'(0));
    endtask

    // Called during an IDLE cycle; finishes in the IDLE cycle after the response.
    // done_at >= TO means the bench never completes the access.
    task automatic run_txn(input logic [NR-1:0] rv, input int done_at, input logic perr,
                           input logic [DW-1:0] rdat);
        int            w;
        int            last_k;
        logic [NR-1:0] exp_g;
        logic          exp_err;
        logic [DW-1:0] exp_rd;
        drive_reqs(rv);
        if (rv == '0) begin
            tick();
            check_quiet("noreq");
            return;
        end
        w      = model_pick(rv);
        exp_g  = NR'(1) << w;
        last_k = (done_at < TO) ? done_at : TO - 1;
        tick();
        for (int k = 0; k <= last_k; k++) begin
            check_eq("xfer_gnt",      32'(gnt), 32'(exp_g));
            check_eq("xfer_transfer", 32'(transfer), 32'(1));
            check_eq("xfer_busy",     32'(busy), 32'(1));
            check_eq("xfer_done",     32'(done), 32'(0));
            check_eq("xfer_rw",       32'(READ_WRITE), 32'(m_rw[w]));
            check_eq("xfer_wpaddr",   32'(apb_write_paddr), 32'(m_rw[w] ? AW'(0) : m_addr[w]));
            check_eq("xfer_rpaddr",   32'(apb_read_paddr), 32'(m_rw[w] ? m_addr[w] : AW'(0)));
            check_eq("xfer_wdata",    32'(apb_write_data), 32'(m_rw[w] ? DW'(0) : m_wdata[w]));
            apb_done          = (k == done_at);
            PSLVERR           = (k == done_at) ? perr : 1'($urandom);
            apb_read_data_out = (k == done_at) ? rdat : DW'($urandom);
            scramble_reqs(w);
            drive_reqs(NR'($urandom));
            tick();
        end
        exp_err = (done_at < TO) ? perr : 1'b1;
        exp_rd  = (done_at < TO && m_rw[w]) ? rdat : DW'(0);
        check_eq("resp_done",     32'(done), 32'(exp_g));
        check_eq("resp_gnt",      32'(gnt), 32'(exp_g));
        check_eq("resp_err",      32'(rsp_err), 32'(exp_err));
        check_eq("resp_rdata",    32'(rsp_rdata), 32'(exp_rd));
        check_eq("resp_transfer", 32'(transfer), 32'(0));
        check_eq("resp_busy",     32'(busy), 32'(1));
        check_eq("resp_cmd",      32'({READ_WRITE, apb_write_paddr, apb_read_paddr, apb_write_data}), 32'(0));
        m_last = w;
        apb_done          = 1'($urandom);
        PSLVERR           = 1'($urandom);
        apb_read_data_out = DW'($urandom);
        tick();
        check_quiet("post_idle");
        apb_done = 1'($urandom);
    endtask

    // Asynchronous reset pulse started between clock edges; outputs must clear before the next edge.
    task automatic pulse_reset();
        #3 PRESET = 1'b1;
        #1 check_quiet("async_rst");
        tick();
        PRESET = 1'b0;
        m_last = NR - 1;
        check_quiet("rst_release");
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            m_rw[i] = 1'b0; m_addr[i] = '0; m_wdata[i] = '0;
        end
        m_last = NR - 1;
        tick();
        check_quiet("reset");
        tick();
        PRESET = 1'b0;

        // requester 0 first after reset, then strict rotation with everyone pending
        pulse_reset();
        for (int t = 0; t < 6; t++) begin
            scramble_reqs(-1);
            run_txn(4'b1111, $urandom_range(0, 4), 1'b0, DW'($urandom));
        end

        // directed write, reads with and without slave error
        m_rw[1] = 1'b0; m_addr[1] = 9'h105; m_wdata[1] = 8'hA5;
        run_txn(4'b0010, 2, 1'b0, 8'h77);
        m_rw[2] = 1'b1; m_addr[2] = 9'h012; m_wdata[2] = 8'h00;
        run_txn(4'b0100, 1, 1'b0, 8'h3C);
        run_txn(4'b0100, 0, 1'b1, 8'h3C);

        // timeout with no completion, then completion exactly in the last allowed cycle
        m_rw[0] = 1'b1; m_addr[0] = 9'h1F0;
        run_txn(4'b0001, 100, 1'b0, 8'h55);
        run_txn(4'b0001, TO - 1, 1'b1, 8'h66);
        run_txn(4'b0001, TO - 1, 1'b0, 8'h99);

        // reset during XFER of requester 3 drops it; it is granted again afterwards
        scramble_reqs(-1);
        drive_reqs(4'b1000);
        tick();
        check_eq("pre_rst_gnt",      32'(gnt), 32'(4'b1000));
        check_eq("pre_rst_transfer", 32'(transfer), 32'(1));
        apb_done = 1'b0;
        tick();
        pulse_reset();
        run_txn(4'b1000, 1, 1'b0, DW'($urandom));

        for (int t = 0; t < 150; t++) begin
            if ($urandom_range(0, 24) == 0) pulse_reset();
            scramble_reqs(-1);
            run_txn(NR'($urandom), $urandom_range(0, TO + 3), 1'($urandom), DW'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
